// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution window controller.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } conv_ctrl_state_t;

    localparam int unsigned MIN_CNT_W = 1;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? MIN_CNT_W : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position counter: col wraps at IMG_W-1 and carries into row; flags the last pixel.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int COL_W = cnt_w(IMG_W),
    parameter int ROW_W = cnt_w(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign last = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/conv_window_ctrl.sv
// Delay-line window sequencer: accepts one raster frame and flags complete KxK windows.
// Optional build macro CONV_WIN_STRIDE2_EN restricts windows to even row/col (stride 2).
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     sr_en,
    output logic [WIDTH-1:0]         sr_data,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_K1 = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_K1 = ROW_W'(K - 1);

    conv_ctrl_state_t state, state_next;

    logic             accept;
    logic             clear;
    logic             last;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] wc;
    logic [ROW_W-1:0] wr;
    logic             win_hit;
    logic             win_ok;

    assign in_ready = (state == RUN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign clear    = (state == IDLE) && start;

    conv_pos_counter #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .inc  (accept),
        .col  (col),
        .row  (row),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: next-state defaults to the current state before the case, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Offsets are only consumed while win_hit holds, so they never underflow in use.
    assign win_hit = (row >= ROW_K1) && (col >= COL_K1);
    assign wr      = row - ROW_K1;
    assign wc      = col - COL_K1;

`ifdef CONV_WIN_STRIDE2_EN
    assign win_ok = win_hit && !wr[0] && !wc[0];
`else
    assign win_ok = win_hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_en     <= 1'b0;
            sr_data   <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            sr_en     <= accept;
            win_valid <= accept && win_ok;
            if (accept) begin
                sr_data <= in_data;
                win_row <= wr;
                win_col <= wc;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: 4x4 and 5x5 frames with K=3.
module tb_conv_window_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4x4 instance
    logic        start4 = 1'b0, in_valid4 = 1'b0;
    logic [17:0] in_data4 = '0;
    logic        busy4, done4, in_ready4, sr_en4, win_valid4;
    logic [17:0] sr_data4;
    logic [1:0]  win_row4, win_col4;

    conv_window_ctrl #(.WIDTH(18), .IMG_W(4), .IMG_H(4), .K(3)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .sr_en(sr_en4), .sr_data(sr_data4), .win_valid(win_valid4),
        .win_row(win_row4), .win_col(win_col4)
    );

    // 5x5 instance
    logic        start5 = 1'b0, in_valid5 = 1'b0;
    logic [17:0] in_data5 = '0;
    logic        busy5, done5, in_ready5, sr_en5, win_valid5;
    logic [17:0] sr_data5;
    logic [2:0]  win_row5, win_col5;

    conv_window_ctrl #(.WIDTH(18), .IMG_W(5), .IMG_H(5), .K(3)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .sr_en(sr_en5), .sr_data(sr_data5), .win_valid(win_valid5),
        .win_row(win_row5), .win_col(win_col5)
    );

    typedef struct {
        logic [17:0] data;
        logic        win;
        logic [1:0]  r;
        logic [1:0]  c;
    } vec_t;

    vec_t vecs [16];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    always @(posedge clk) if (done4) done_cnt <= done_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 4x4 frame; gap idles in_valid between pixels, noise pulses start in RUN and DONE.
    task automatic run_frame(input bit gap, input bit noise);
        int cycles;
        int d0;
        d0 = done_cnt;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        cycles = 1;
        check("busy_rise", busy4, 1);
        check("in_ready_run", in_ready4, 1);
        for (int i = 0; i < 16; i++) begin
            in_valid4 = 1'b1;
            in_data4  = vecs[i].data;
            if (noise && i == 5) start4 = 1'b1;
            step();
            cycles++;
            start4    = 1'b0;
            in_valid4 = 1'b0;
            check("sr_en_acc", sr_en4, 1);
            check("sr_data", sr_data4, vecs[i].data);
            check("win_valid", win_valid4, vecs[i].win);
            if (vecs[i].win) begin
                check("win_row", win_row4, vecs[i].r);
                check("win_col", win_col4, vecs[i].c);
            end
            check("done_pos", done4, (i == 15));
            if (i == 15 && !gap) check("done_latency", cycles, 17);
            if (gap && i != 15) begin
                step();
                cycles++;
                check("sr_en_gap", sr_en4, 0);
                check("win_valid_gap", win_valid4, 0);
                check("sr_data_hold", sr_data4, vecs[i].data);
                check("done_gap", done4, 0);
            end
        end
        if (noise) begin
            start4 = 1'b1;
            step();
            start4 = 1'b0;
            check("busy_fall_noise", busy4, 0);
            check("in_ready_idle", in_ready4, 0);
            step();
            check("start_not_queued", busy4, 0);
        end else begin
            step();
            check("busy_fall", busy4, 0);
            check("done_clear", done4, 0);
        end
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int act_win;
        int exp_win_total;
        int r;
        int c;
        bit exp;

        for (int i = 0; i < 16; i++) begin
            vecs[i].data = 18'(i);
            vecs[i].win  = 1'b0;
            vecs[i].r    = 2'd0;
            vecs[i].c    = 2'd0;
        end
        vecs[10].win = 1'b1; vecs[10].r = 2'd0; vecs[10].c = 2'd0;
`ifndef CONV_WIN_STRIDE2_EN
        vecs[11].win = 1'b1; vecs[11].r = 2'd0; vecs[11].c = 2'd1;
        vecs[14].win = 1'b1; vecs[14].r = 2'd1; vecs[14].c = 2'd0;
        vecs[15].win = 1'b1; vecs[15].r = 2'd1; vecs[15].c = 2'd1;
`endif

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_in_ready", in_ready4, 0);
        check("rst_sr_en", sr_en4, 0);
        check("rst_win_valid", win_valid4, 0);
        check("rst_sr_data", sr_data4, 0);
        check("rst_win_row", win_row4, 0);
        check("rst_win_col", win_col4, 0);
        rst = 1'b0;
        step();
        check("idle_no_start", busy4, 0);

        // Continuous frames back to back (start in first IDLE cycle), gapped, and start noise
        run_frame(1'b0, 1'b0);
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        run_frame(1'b0, 1'b1);

        // Mid-frame reset after 7 accepted pixels
        d0 = done_cnt;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 18'(100 + i);
            step();
        end
        in_valid4 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy4, 0);
        check("abort_sr_en", sr_en4, 0);
        check("abort_win_valid", win_valid4, 0);
        check("abort_sr_data", sr_data4, 0);
        check("abort_done", done4, 0);
        step();
        step();
        check("abort_no_done", done_cnt - d0, 0);
        run_frame(1'b0, 1'b0);

        // 5x5 frame, stride depends on build
        act_win = 0;
        start5 = 1'b1;
        step();
        start5 = 1'b0;
        for (int p = 0; p < 25; p++) begin
            in_valid5 = 1'b1;
            in_data5  = 18'(p + 7);
            step();
            in_valid5 = 1'b0;
            r = p / 5;
            c = p % 5;
            exp = (r >= 2) && (c >= 2);
`ifdef CONV_WIN_STRIDE2_EN
            exp = exp && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`endif
            check("win5_valid", win_valid5, exp);
            if (exp) begin
                check("win5_row", win_row5, r - 2);
                check("win5_col", win_col5, c - 2);
            end
            check("sr_data5", sr_data5, p + 7);
            act_win += int'(win_valid5);
        end
        check("done5", done5, 1);
`ifdef CONV_WIN_STRIDE2_EN
        exp_win_total = 4;
`else
        exp_win_total = 9;
`endif
        check("win5_count", act_win, exp_win_total);
        step();
        check("busy5_fall", busy5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
